// File: rtl/uart_pkg.sv
// Shared types and constants for the byte-wide UART receiver.
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        PARITY  = 3'd3,
        STOP    = 3'd4,
        RECOVER = 3'd5
    } state_t;

endpackage

// File: rtl/baud_tick_gen.sv
// Free-running 16x oversample tick: one-clock pulse every CLK_FREQ/(BAUD_RATE*16) clocks.
module baud_tick_gen
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 100000000,
    parameter int BAUD_RATE = 115200
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int DIV_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int CW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_rx_byte.sv
// UART byte receiver, 16x oversampled, 8 data bits LSB first.
// Optional even parity bit when UART_RX_PARITY_EN is defined.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   IDLE    | line high, waiting for a falling edge
//   START   | confirm start bit at its midpoint (glitch filter)
//   DATA    | sample 8 data bits, one per bit time
//   PARITY  | sample the even parity bit (parity builds only)
//   STOP    | sample stop bit, publish byte or flag error
//   RECOVER | wait for a full bit time of continuous idle
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 100000000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_ready,
    output logic       frame_error,
    output logic       parity_error
);

    localparam logic [3:0] MID_LAST = 4'(MID_SAMPLE - 1);
    localparam logic [3:0] BIT_LAST = 4'(OVERSAMPLE - 1);

`ifdef UART_RX_PARITY_EN
    localparam state_t AFTER_DATA = PARITY;
`else
    localparam state_t AFTER_DATA = STOP;
`endif

    logic       tick;
    logic       rx_s1_q, rx_s2_q;
    state_t     state_q, state_d;
    logic [3:0] tick_cnt_q, tick_cnt_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] data_q, data_d;
    logic       ready_q, ready_d;
    logic       ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
    logic       mismatch_q, mismatch_d;
    logic       perr_q, perr_d;
`endif

    baud_tick_gen #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD_RATE(BAUD_RATE)
    ) u_tick (
        .clk  (clk),
        .reset(reset),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
        end else begin
            rx_s1_q <= rx;
            rx_s2_q <= rx_s1_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        data_d     = data_q;
        ready_d    = 1'b0;
        ferr_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
        mismatch_d = mismatch_q;
        perr_d     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (!rx_s2_q) begin
                    state_d    = START;
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
`ifdef UART_RX_PARITY_EN
                    mismatch_d = 1'b0;
`endif
                end
            end
            START: begin
                if (tick) begin
                    if (tick_cnt_q == MID_LAST) begin
                        tick_cnt_d = '0;
                        state_d    = rx_s2_q ? IDLE : DATA;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (tick_cnt_q == BIT_LAST) begin
                        tick_cnt_d = '0;
                        shift_d    = {rx_s2_q, shift_q[7:1]};
                        bit_cnt_d  = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = AFTER_DATA;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
            PARITY: begin
`ifdef UART_RX_PARITY_EN
                if (tick) begin
                    if (tick_cnt_q == BIT_LAST) begin
                        tick_cnt_d = '0;
                        mismatch_d = rx_s2_q ^ (^shift_q);
                        state_d    = STOP;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
`else
                state_d = IDLE;
`endif
            end
            STOP: begin
                if (tick) begin
                    if (tick_cnt_q == BIT_LAST) begin
                        tick_cnt_d = '0;
                        if (!rx_s2_q) begin
                            ferr_d  = 1'b1;
                            state_d = RECOVER;
`ifdef UART_RX_PARITY_EN
                        end else if (mismatch_q) begin
                            perr_d  = 1'b1;
                            state_d = IDLE;
`endif
                        end else begin
                            ready_d = 1'b1;
                            data_d  = shift_q;
                            state_d = IDLE;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
            RECOVER: begin
                // Any low sample restarts the idle qualification window.
                if (!rx_s2_q) begin
                    tick_cnt_d = '0;
                end else if (tick) begin
                    if (tick_cnt_q == BIT_LAST) begin
                        tick_cnt_d = '0;
                        state_d    = IDLE;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            ready_q    <= 1'b0;
            ferr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            mismatch_q <= 1'b0;
            perr_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            ready_q    <= ready_d;
            ferr_q     <= ferr_d;
`ifdef UART_RX_PARITY_EN
            mismatch_q <= mismatch_d;
            perr_q     <= perr_d;
`endif
        end
    end

    assign rx_data     = data_q;
    assign rx_ready    = ready_q;
    assign frame_error = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign parity_error = perr_q;
`else
    assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte at 100 MHz / 115200 baud (864 clocks per bit).
module tb_uart_rx_byte;
    import uart_pkg::*;

    localparam int BIT_CLKS = 864;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CLKS = BIT_CLKS * FRAME_BITS;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       frame_error;
    logic       parity_error;

    int checks = 0;
    int failures = 0;

    int          cyc = 0;
    int          ready_cnt = 0;
    int          fe_cnt = 0;
    int          pe_cnt = 0;
    int          overlap_cnt = 0;
    logic [7:0]  data_log [$];
    int          cyc_log [$];

    uart_rx_byte #(
        .CLK_FREQ (100000000),
        .BAUD_RATE(115200)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx          (rx),
        .rx_data     (rx_data),
        .rx_ready    (rx_ready),
        .frame_error (frame_error),
        .parity_error(parity_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_ready) begin
            ready_cnt <= ready_cnt + 1;
            data_log.push_back(rx_data);
            cyc_log.push_back(cyc);
        end
        if (frame_error)  fe_cnt <= fe_cnt + 1;
        if (parity_error) pe_cnt <= pe_cnt + 1;
        if ($countones({rx_ready, frame_error, parity_error}) > 1) overlap_cnt <= overlap_cnt + 1;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic par_v);
        rx = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_clks(BIT_CLKS);
        end
`ifdef UART_RX_PARITY_EN
        rx = par_v;
        wait_clks(BIT_CLKS);
`endif
        rx = stop_v;
        wait_clks(BIT_CLKS);
    endtask

    task automatic test_reset;
        reset = 1'b0;
        rx = 1'b1;
        wait_clks(5);
        checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
        checks++; if (rx_ready !== 1'b0) begin failures++; $display("FAIL reset_rx_ready got=%b exp=0", rx_ready); end
        checks++; if (frame_error !== 1'b0) begin failures++; $display("FAIL reset_frame_error got=%b exp=0", frame_error); end
        checks++; if (parity_error !== 1'b0) begin failures++; $display("FAIL reset_parity_error got=%b exp=0", parity_error); end
        checks++; if (dut.state_q !== IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", dut.state_q, IDLE); end
        reset = 1'b1;
        wait_clks(20);
    endtask

    task automatic test_single;
        int r0, f0, p0;
        r0 = ready_cnt; f0 = fe_cnt; p0 = pe_cnt;
        send_frame(8'hA5, 1'b1, 1'b0);
        rx = 1'b1;
        wait_clks(50);
        checks++; if (ready_cnt - r0 !== 1) begin failures++; $display("FAIL single_ready_count got=%0d exp=1", ready_cnt - r0); end
        checks++; if (rx_data !== 8'hA5) begin failures++; $display("FAIL single_rx_data got=%h exp=a5", rx_data); end
        checks++; if ((fe_cnt - f0) + (pe_cnt - p0) !== 0) begin failures++; $display("FAIL single_errors got=%0d exp=0", (fe_cnt - f0) + (pe_cnt - p0)); end
    endtask

    task automatic test_back_to_back;
        int r0;
        logic [7:0] exp_b [3];
        exp_b[0] = 8'h00; exp_b[1] = 8'hFF; exp_b[2] = 8'h3C;
        r0 = ready_cnt;
        for (int k = 0; k < 3; k++) send_frame(exp_b[k], 1'b1, ^exp_b[k]);
        rx = 1'b1;
        wait_clks(50);
        checks++;
        if (ready_cnt - r0 !== 3) begin
            failures++; $display("FAIL b2b_ready_count got=%0d exp=3", ready_cnt - r0);
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (data_log[r0 + k] !== exp_b[k]) begin failures++; $display("FAIL b2b_data%0d got=%h exp=%h", k, data_log[r0 + k], exp_b[k]); end
            end
            for (int k = 1; k < 3; k++) begin
                checks++;
                if (cyc_log[r0 + k] - cyc_log[r0 + k - 1] !== FRAME_CLKS) begin
                    failures++; $display("FAIL b2b_spacing%0d got=%0d exp=%0d", k, cyc_log[r0 + k] - cyc_log[r0 + k - 1], FRAME_CLKS);
                end
            end
        end
    endtask

    task automatic test_glitch;
        int r0, f0, p0;
        r0 = ready_cnt; f0 = fe_cnt; p0 = pe_cnt;
        rx = 1'b0;
        wait_clks(200);
        rx = 1'b1;
        wait_clks(600);
        checks++; if (dut.state_q !== IDLE) begin failures++; $display("FAIL glitch_state got=%0d exp=%0d", dut.state_q, IDLE); end
        checks++; if ((ready_cnt - r0) + (fe_cnt - f0) + (pe_cnt - p0) !== 0) begin failures++; $display("FAIL glitch_pulses got=%0d exp=0", (ready_cnt - r0) + (fe_cnt - f0) + (pe_cnt - p0)); end
        checks++; if (rx_data !== 8'h3C) begin failures++; $display("FAIL glitch_rx_data got=%h exp=3c", rx_data); end
    endtask

    task automatic test_frame_error;
        int r0, f0;
        r0 = ready_cnt; f0 = fe_cnt;
        send_frame(8'h5A, 1'b0, 1'b0);
        wait_clks(2000);
        checks++; if (fe_cnt - f0 !== 1) begin failures++; $display("FAIL ferr_count got=%0d exp=1", fe_cnt - f0); end
        checks++; if (ready_cnt - r0 !== 0) begin failures++; $display("FAIL ferr_ready got=%0d exp=0", ready_cnt - r0); end
        checks++; if (dut.state_q !== RECOVER) begin failures++; $display("FAIL ferr_state got=%0d exp=%0d", dut.state_q, RECOVER); end
        checks++; if (rx_data !== 8'h3C) begin failures++; $display("FAIL ferr_rx_data_hold got=%h exp=3c", rx_data); end
        rx = 1'b1;
        wait_clks(1000);
        checks++; if (dut.state_q !== IDLE) begin failures++; $display("FAIL ferr_recovered got=%0d exp=%0d", dut.state_q, IDLE); end
        send_frame(8'h11, 1'b1, 1'b0);
        rx = 1'b1;
        wait_clks(50);
        checks++; if (rx_data !== 8'h11) begin failures++; $display("FAIL ferr_next_byte got=%h exp=11", rx_data); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity;
        int r0, p0;
        r0 = ready_cnt; p0 = pe_cnt;
        send_frame(8'h07, 1'b1, 1'b0);
        rx = 1'b1;
        wait_clks(50);
        checks++; if (pe_cnt - p0 !== 1) begin failures++; $display("FAIL par_bad_perr got=%0d exp=1", pe_cnt - p0); end
        checks++; if (ready_cnt - r0 !== 0) begin failures++; $display("FAIL par_bad_ready got=%0d exp=0", ready_cnt - r0); end
        checks++; if (rx_data !== 8'h11) begin failures++; $display("FAIL par_bad_hold got=%h exp=11", rx_data); end
        send_frame(8'h07, 1'b1, 1'b1);
        rx = 1'b1;
        wait_clks(50);
        checks++; if (ready_cnt - r0 !== 1) begin failures++; $display("FAIL par_good_ready got=%0d exp=1", ready_cnt - r0); end
        checks++; if (pe_cnt - p0 !== 1) begin failures++; $display("FAIL par_good_perr got=%0d exp=1", pe_cnt - p0); end
        checks++; if (rx_data !== 8'h07) begin failures++; $display("FAIL par_good_data got=%h exp=07", rx_data); end
    endtask
`endif

    task automatic test_reset_midframe;
        logic [7:0] b;
        int r0, f0, p0;
        b = 8'hC3;
        rx = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            wait_clks(BIT_CLKS);
        end
        rx = b[4];
        wait_clks(400);
        #2 reset = 1'b0;
        #1;
        checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL mid_rst_rx_data got=%h exp=00", rx_data); end
        checks++; if ({rx_ready, frame_error, parity_error} !== 3'b000) begin failures++; $display("FAIL mid_rst_pulses got=%b exp=000", {rx_ready, frame_error, parity_error}); end
        checks++; if (dut.state_q !== IDLE) begin failures++; $display("FAIL mid_rst_state got=%0d exp=%0d", dut.state_q, IDLE); end
        rx = 1'b1;
        wait_clks(10);
        reset = 1'b1;
        r0 = ready_cnt; f0 = fe_cnt; p0 = pe_cnt;
        wait_clks(900);
        checks++; if ((ready_cnt - r0) + (fe_cnt - f0) + (pe_cnt - p0) !== 0) begin failures++; $display("FAIL mid_rst_no_pulse got=%0d exp=0", (ready_cnt - r0) + (fe_cnt - f0) + (pe_cnt - p0)); end
        send_frame(8'h81, 1'b1, 1'b0);
        rx = 1'b1;
        wait_clks(50);
        checks++; if (ready_cnt - r0 !== 1) begin failures++; $display("FAIL mid_rst_ready got=%0d exp=1", ready_cnt - r0); end
        checks++; if (rx_data !== 8'h81) begin failures++; $display("FAIL mid_rst_data got=%h exp=81", rx_data); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_glitch;
        test_frame_error;
`ifdef UART_RX_PARITY_EN
        test_parity;
`endif
        test_reset_midframe;
        checks++; if (overlap_cnt !== 0) begin failures++; $display("FAIL pulse_exclusive got=%0d exp=0", overlap_cnt); end
`ifndef UART_RX_PARITY_EN
        checks++; if (pe_cnt !== 0) begin failures++; $display("FAIL parity_tied got=%0d exp=0", pe_cnt); end
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_byte.md
UART_RX_BYTE -- requirements
Module: uart_rx_byte

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100000000: system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200: serial bit rate.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic rising-edge.
REQ-004 SHALL have port reset, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port rx, input, 1 bit: asynchronous serial line, idle high.
REQ-006 SHALL have port rx_data, output, 8 bits: last correctly received byte.
REQ-007 SHALL have port rx_ready, output, 1 bit: one-clock pulse when rx_data is valid; drives the downstream pixel assembler's byte-ready input.
REQ-008 SHALL have port frame_error, output, 1 bit: one-clock pulse on a bad stop bit.
REQ-009 SHALL have port parity_error, output, 1 bit: one-clock pulse on parity mismatch.

Function
REQ-010 SHALL pass rx through a 2-flop synchronizer; both flops reset to 1.
REQ-011 SHALL generate a sample tick every DIV = CLK_FREQ/(BAUD_RATE*16) clocks (integer division, 16x oversampling). The tick counter SHALL wrap to 0 after DIV-1 and SHALL free-run.
REQ-012 SHALL implement states IDLE, START, DATA, PARITY, STOP, RECOVER.
REQ-013 IDLE: a synchronized rx of 0 SHALL move the FSM to START and clear the tick count.
REQ-014 START: after 8 ticks, rx=0 SHALL move to DATA; rx=1 SHALL return to IDLE with no output pulse (glitch rejection).
REQ-015 DATA: SHALL sample every 16 ticks, LSB first, shifting into an 8-bit register. A 3-bit bit counter SHALL advance each sample. After bit 7 the FSM SHALL go to PARITY if parity is compiled in, else to STOP.
REQ-016 PARITY: SHALL sample after 16 ticks. A sampled bit not equal to the even parity of the data SHALL set an internal mismatch flag. The FSM SHALL then go to STOP.
REQ-017 STOP, sample rx=1 after 16 ticks, no mismatch: on the next clock rx_data SHALL load the shift register and rx_ready SHALL pulse for exactly 1 clock. The FSM SHALL return to IDLE.
REQ-018 STOP, rx=1 with mismatch: parity_error SHALL pulse 1 clock; rx_data and rx_ready SHALL be unchanged. The FSM SHALL go to IDLE.
REQ-019 STOP, rx=0: frame_error SHALL pulse 1 clock; rx_data and rx_ready SHALL be unchanged. The FSM SHALL go to RECOVER.
REQ-020 RECOVER: SHALL stay until 16 consecutive ticks with rx=1, then go to IDLE (break/low-line protection).
REQ-021 rx_ready, frame_error and parity_error SHALL be mutually exclusive in any cycle.
REQ-022 rx_data SHALL hold its value between valid bytes; back-to-back frames with no idle gap SHALL be received without loss.

Reset
REQ-023 reset=0 SHALL force, asynchronously: state=IDLE, rx_data=0, rx_ready=0, frame_error=0, parity_error=0, all counters=0, synchronizer=1.
REQ-024 reset asserted mid-frame SHALL discard the partial byte. After release, reception SHALL resume only on a new falling edge detected from IDLE.

Configuration
REQ-025 Macro UART_RX_PARITY_EN defined: the PARITY state SHALL be active and frames SHALL be 11 bits (start, 8 data, even parity, stop).
REQ-026 Macro undefined: PARITY SHALL be unreachable, frames SHALL be 10 bits, and parity_error SHALL be tied to 0.

Structure
REQ-027 Package uart_pkg SHALL hold the state enum typedef, OVERSAMPLE=16, and MID_SAMPLE=8.
REQ-028 The tick generator SHALL be sub-module baud_tick_gen (parameters CLK_FREQ, BAUD_RATE; output tick).

Verification (CLK_FREQ=100e6, BAUD_RATE=115200, DIV=54; bit time 864 clocks)
REQ-029 Send 0xA5, 8N1 -> exactly one rx_ready pulse, rx_data=0xA5, no error pulses.
REQ-030 Send 0x00, 0xFF, 0x3C back-to-back -> three rx_ready pulses carrying those values in order, spaced 8640 clocks apart.
REQ-031 Low glitch of 200 clocks on idle rx -> FSM returns to IDLE, no pulses, rx_data unchanged.
REQ-032 Send 0x5A with stop bit forced 0, then hold rx low for 2000 clocks -> one frame_error pulse, FSM held in RECOVER. Next 0x11 after line idle -> rx_data=0x11.
REQ-033 With UART_RX_PARITY_EN: 0x07 with parity bit 0 -> parity_error pulse, no rx_ready. 0x07 with parity bit 1 -> rx_ready, rx_data=0x07.
REQ-034 Assert reset at data bit 4 of 0xC3 -> all outputs 0 immediately. After release, 0x81 -> rx_data=0x81.
